fifo_burst_reader: RTL and testbench

- Drain-side controller for the team's synchronous FIFO.
- On a start command it reads exactly burst_len words from the FIFO read port (re_en / registered data_out / empty), then presents them as a valid/ready stream.
- Compensates the FIFO's 1-cycle read latency with a small internal output buffer, sustaining 1 word/cycle when the FIFO is non-empty and the sink is ready.
- Sits between the FIFO and any downstream stream consumer.

---
 rtl/fifo_reader_pkg.sv | 28 ++
 rtl/reader_out_buf.sv | 72 +++++++
 rtl/fifo_burst_reader.sv | 195 +++++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// -----------------------------------------------------------------------------
// fifo_reader_pkg
// Shared types and constants for the FIFO burst reader.
//   reader_state_t : controller states (IDLE, FETCH, DRAIN)
//   OUT_DEPTH      : entries in the output buffer that hides the FIFO read latency
//   PTR_W / CNT_W  : pointer width and occupancy-count width for that buffer
//   occupancy()    : buffered words plus the word still returning from the FIFO
// -----------------------------------------------------------------------------
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } reader_state_t;

  localparam int OUT_DEPTH = 4;
  localparam int PTR_W     = $clog2(OUT_DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  // A word that has been issued but not yet written still needs a buffer slot,
  // so it counts against the buffer capacity.
  function automatic logic [CNT_W-1:0] occupancy(input logic [CNT_W-1:0] bufCount,
                                                 input logic             inflight);
    return bufCount + CNT_W'(inflight);
  endfunction

endpackage

// File: rtl/reader_out_buf.sv
// -----------------------------------------------------------------------------
// reader_out_buf
// Small circular buffer between the FIFO read data and the output stream.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (clears storage too)
//   flush       : synchronous discard of all contents
//   push/pushData : write one word at the tail
//   pop         : remove the head word (ignored when empty)
//   headData    : word at the head; held stable until it is popped
//   count       : number of stored words (0..OUT_DEPTH)
// -----------------------------------------------------------------------------
module reader_out_buf
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] pushData,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] headData,
  output logic [CNT_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] mem_q [OUT_DEPTH];
  logic [PTR_W-1:0]      wrPtr_q;
  logic [PTR_W-1:0]      rdPtr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  doPop;
  logic                  doPush;

  // Pops on an empty buffer are dropped; a push into a full buffer is only
  // legal when a pop frees the head slot in the same cycle.
  assign doPop  = pop & (count_q != '0);
  assign doPush = push & ((count_q != CNT_W'(OUT_DEPTH)) | doPop);

  // Storage, pointers and count. The pointers are exactly PTR_W bits wide so
  // they wrap around the ring without any explicit compare.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= pushData;
        wrPtr_q        <= wrPtr_q + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign headData = mem_q[rdPtr_q];
  assign count    = count_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
// Drain-side controller for the synchronous FIFO: on start it reads exactly
// burst_len words and presents them on a valid/ready stream at up to one word
// per cycle, hiding the FIFO's one-cycle read latency with reader_out_buf.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   start, burst_len      : burst request and length, sampled in IDLE only
//   busy, done            : burst in progress / one-cycle end-of-burst pulse
//   words_left            : words not yet accepted downstream
//   fifo_empty, fifo_re_en, fifo_data : FIFO read port (data valid one cycle
//                           after the read is issued)
//   m_valid, m_data, m_ready : output stream
//   abort, aborted        : only with READER_ABORT_EN defined; abort cancels a
//                           running burst, aborted pulses with done
// Build option: `define READER_ABORT_EN to add the abort feature.
// -----------------------------------------------------------------------------
module fifo_burst_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  words_left,
  input  logic                  fifo_empty,
  output logic                  fifo_re_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
`ifdef READER_ABORT_EN
  ,
  input  logic                  abort,
  output logic                  aborted
`endif
);

  reader_state_t         state_q, state_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [LEN_WIDTH-1:0]  wordsLeft_q, wordsLeft_d;
  logic                  inflight_q;
  logic                  done_q, done_d;
  logic [CNT_W-1:0]      bufCount;
  logic [DATA_WIDTH-1:0] bufHead;
  logic                  streamValid;
  logic                  issue;
  logic                  bufPush;
  logic                  bufPop;
  logic                  abortHit;

`ifdef READER_ABORT_EN
  logic aborted_q;
  assign abortHit = abort & (state_q != IDLE);
`else
  assign abortHit = 1'b0;
`endif

  // A read is issued only when a buffer slot is guaranteed for the returning
  // word, so the buffer can never overflow whatever m_ready does. Nothing here
  // looks at m_ready, which keeps the sink out of the FIFO read path.
  assign issue = (state_q == FETCH) & ~fifo_empty & (remaining_q != '0)
               & (occupancy(bufCount, inflight_q) < CNT_W'(OUT_DEPTH))
               & ~abortHit;

  assign streamValid = (bufCount != '0);
  assign bufPop      = streamValid & m_ready & ~abortHit;
  // The FIFO data register is only meaningful the cycle after an issue.
  assign bufPush     = inflight_q & ~abortHit;

  reader_out_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_buf (
    .clk      (clk),
    .reset    (reset),
    .flush    (abortHit),
    .push     (bufPush),
    .pushData (fifo_data),
    .pop      (bufPop),
    .headData (bufHead),
    .count    (bufCount)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. FETCH leaves on the cycle the last read is issued;
  // DRAIN waits until the returning word and every buffered word are gone.
  // done_d is raised on every transition that ends a burst, including a
  // zero-length request that never leaves IDLE.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            state_d = FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (issue && (remaining_q == LEN_WIDTH'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((bufCount == '0) && !inflight_q && (wordsLeft_q == '0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abortHit) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end

  // FSM outputs.
  always_comb begin
    busy       = (state_q != IDLE);
    fifo_re_en = issue;
  end

  // Counter next values: both counters load from burst_len on an accepted
  // start. remaining counts reads still to issue, words_left counts words
  // still to be accepted by the sink.
  always_comb begin
    remaining_d = remaining_q;
    wordsLeft_d = wordsLeft_q;
    if ((state_q == IDLE) && start) begin
      remaining_d = burst_len;
      wordsLeft_d = burst_len;
    end else if (abortHit) begin
      remaining_d = '0;
      wordsLeft_d = '0;
    end else begin
      if (issue) begin
        remaining_d = remaining_q - LEN_WIDTH'(1);
      end
      if (bufPop && (wordsLeft_q != '0)) begin
        wordsLeft_d = wordsLeft_q - LEN_WIDTH'(1);
      end
    end
  end

  // Datapath registers. Reset drops any word still in flight; the FIFO has
  // already advanced past it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining_q <= '0;
      wordsLeft_q <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      wordsLeft_q <= wordsLeft_d;
      inflight_q  <= issue;
      done_q      <= done_d;
    end
  end

`ifdef READER_ABORT_EN
  // aborted pulses alongside done on the cycle after a cancel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= abortHit;
    end
  end
  assign aborted = aborted_q;
`endif

  assign done       = done_q;
  assign words_left = wordsLeft_q;
  assign m_valid    = streamValid;
  assign m_data     = bufHead;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_burst_reader
// Directed bench for fifo_burst_reader. A behavioural FIFO feeds the read port;
// expected stream words are queued when each burst is requested and popped
// whenever the sink accepts a word. Define READER_ABORT_EN to add abort cases.
// -----------------------------------------------------------------------------
module tb_fifo_burst_reader;

  localparam int DW = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic          busy;
  logic          done;
  logic [LW-1:0] words_left;
  logic          fifo_empty = 1'b1;
  logic          fifo_re_en;
  logic [DW-1:0] fifo_data = '0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
`ifdef READER_ABORT_EN
  logic          abort = 1'b0;
  logic          aborted;
`endif

  logic          wrEn = 1'b0;
  logic [DW-1:0] wrData = '0;
  logic [DW-1:0] fifoMem[$];
  logic [DW-1:0] expQ[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int reCount, reWhileEmpty, doneCount, accepted, valCount;
  int reFirst, reLast, accFirst, accLast;
  logic          holdValid = 1'b0;
  logic [DW-1:0] holdData = '0;

  fifo_burst_reader #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .burst_len  (burst_len),
    .busy       (busy),
    .done       (done),
    .words_left (words_left),
    .fifo_empty (fifo_empty),
    .fifo_re_en (fifo_re_en),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready)
`ifdef READER_ABORT_EN
    ,
    .abort      (abort),
    .aborted    (aborted)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural synchronous FIFO: registered read data, empty flag updated on
  // the clock edge, not affected by the reader's reset.
  always @(posedge clk) begin
    if (fifo_re_en && (fifoMem.size() != 0)) begin
      fifo_data <= fifoMem.pop_front();
    end
    if (wrEn) begin
      fifoMem.push_back(wrData);
    end
    fifo_empty <= (fifoMem.size() == 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetStats();
    reCount = 0; reWhileEmpty = 0; doneCount = 0; accepted = 0; valCount = 0;
    reFirst = -1; reLast = -1; accFirst = -1; accLast = -1;
  endtask

  // Stream monitor, sampled mid-cycle on the falling edge.
  task automatic checkOutput();
    logic [DW-1:0] exp;
    if (fifo_re_en === 1'b1) begin
      reCount++;
      if (reFirst < 0) reFirst = cyc;
      reLast = cyc;
      if (fifo_empty) reWhileEmpty++;
    end
    if (done === 1'b1) doneCount++;
    if (m_valid === 1'b1) begin
      valCount++;
      if (holdValid) check("m_data_stable", m_data, holdData);
      if (m_ready) begin
        tests++;
        assert (expQ.size() != 0) else begin
          fails++;
          $error("[TB] FAIL unexpected_word observed=%0h expected=none", m_data);
        end
        if (expQ.size() != 0) begin
          exp = expQ.pop_front();
          check("stream_data", m_data, exp);
        end
        accepted++;
        if (accFirst < 0) accFirst = cyc;
        accLast = cyc;
        holdValid = 1'b0;
      end else begin
        holdValid = 1'b1;
        holdData  = m_data;
      end
    end else begin
      holdValid = 1'b0;
    end
  endtask

  // One clock: monitor on the falling edge, return 1 time unit after the
  // rising edge so inputs can be changed and registered outputs checked.
  task automatic applyStimulus();
    @(negedge clk);
    cyc++;
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      wrEn   = 1'b1;
      wrData = first + DW'(i);
      applyStimulus();
    end
    wrEn = 1'b0;
  endtask

  task automatic startBurst(input logic [LW-1:0] len);
    burst_len = len;
    start     = 1'b1;
    applyStimulus();
    start     = 1'b0;
  endtask

  task automatic runUntilDone(input string tag, input int budget);
    int n = 0;
    while ((doneCount == 0) && (n < budget)) begin
      applyStimulus();
      n++;
    end
    check({tag, "_done_seen"}, (doneCount != 0), 1'b1);
  endtask

  initial begin
    int  written;
    logic sawDone, busyDropped;
    resetStats();

    // Reset state.
    #1 reset = 1'b1;
    applyStimulus();
    applyStimulus();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_re_en", fifo_re_en, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 8'h00);
    check("rst_words_left", words_left, 8'h00);
    reset = 1'b0;
    applyStimulus();

    // Five-word burst with an extra word left behind in the FIFO.
    preload(8'h10, 6);
    resetStats();
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) expQ.push_back(8'h10 + 8'(i));
    startBurst(8'd5);
    runUntilDone("b5", 40);
    repeat (3) applyStimulus();
    check("b5_reads", reCount, 5);
    check("b5_reads_back_to_back", reLast - reFirst + 1, 5);
    check("b5_accepted", accepted, 5);
    check("b5_accept_back_to_back", accLast - accFirst + 1, 5);
    check("b5_first_valid_latency", accFirst - reFirst, 2);
    check("b5_done_once", doneCount, 1);
    check("b5_words_left", words_left, 8'h00);
    check("b5_busy_end", busy, 1'b0);
    check("b5_fifo_left", fifoMem.size(), 1);
    check("b5_exp_drained", expQ.size(), 0);

    // Zero-length request: done next cycle, no reads, no stream words.
    resetStats();
    startBurst(8'd0);
    check("z_done_next", done, 1'b1);
    check("z_busy", busy, 1'b0);
    applyStimulus();
    check("z_done_cleared", done, 1'b0);
    repeat (4) applyStimulus();
    check("z_no_reads", reCount, 0);
    check("z_no_valid", valCount, 0);
    check("z_done_once", doneCount, 1);

    // Single-word burst drains the leftover word.
    resetStats();
    expQ.push_back(8'h15);
    startBurst(8'd1);
    runUntilDone("b1", 20);
    check("b1_accepted", accepted, 1);
    check("b1_fifo_empty", fifoMem.size(), 0);

    // Sink stalled: exactly four reads, then release and collect all eight.
    preload(8'h00, 8);
    resetStats();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) expQ.push_back(8'(i));
    startBurst(8'd8);
    repeat (20) applyStimulus();
    check("stall_reads", reCount, 4);
    check("stall_valid", m_valid, 1'b1);
    check("stall_head", m_data, 8'h00);
    check("stall_words_left", words_left, 8'd8);
    check("stall_busy", busy, 1'b1);
    m_ready = 1'b1;
    runUntilDone("stall", 60);
    check("stall_accepted", accepted, 8);
    check("stall_total_reads", reCount, 8);
    check("stall_exp_drained", expQ.size(), 0);
    check("stall_words_left_end", words_left, 8'h00);

    // FIFO starts empty and is refilled one word every five cycles.
    resetStats();
    for (int i = 0; i < 3; i++) expQ.push_back(8'h20 + 8'(i));
    startBurst(8'd3);
    written = 0; sawDone = 1'b0; busyDropped = 1'b0;
    for (int i = 0; (i < 80) && !sawDone; i++) begin
      if ((i % 5 == 0) && (written < 3)) begin
        wrEn   = 1'b1;
        wrData = 8'h20 + 8'(written);
        written++;
      end else begin
        wrEn = 1'b0;
      end
      applyStimulus();
      if (done) sawDone = 1'b1;
      else if (!busy) busyDropped = 1'b1;
    end
    wrEn = 1'b0;
    check("slow_done_seen", sawDone, 1'b1);
    check("slow_busy_held", busyDropped, 1'b0);
    check("slow_accepted", accepted, 3);
    check("slow_reads", reCount, 3);
    check("slow_no_read_when_empty", reWhileEmpty, 0);

    // Asynchronous reset with two words buffered and one in flight.
    preload(8'h30, 6);
    resetStats();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) expQ.push_back(8'h30 + 8'(i));
    startBurst(8'd6);
    repeat (3) applyStimulus();
    check("pre_rst_valid", m_valid, 1'b1);
    check("pre_rst_head", m_data, 8'h30);
    check("pre_rst_reads", reCount, 3);
    reset = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_valid", m_valid, 1'b0);
    check("arst_data", m_data, 8'h00);
    check("arst_re_en", fifo_re_en, 1'b0);
    check("arst_words_left", words_left, 8'h00);
    check("arst_done", done, 1'b0);
    applyStimulus();
    reset = 1'b0;
    expQ.delete();
    resetStats();
    m_ready = 1'b1;
    expQ.push_back(8'h33);
    expQ.push_back(8'h34);
    startBurst(8'd2);
    runUntilDone("post_rst", 30);
    check("post_rst_accepted", accepted, 2);
    check("post_rst_fifo_left", fifoMem.size(), 1);

`ifdef READER_ABORT_EN
    // Abort after two of six words have been accepted.
    preload(8'h40, 5);
    resetStats();
    m_ready = 1'b1;
    expQ.push_back(8'h35);
    for (int i = 0; i < 5; i++) expQ.push_back(8'h40 + 8'(i));
    startBurst(8'd6);
    for (int i = 0; (i < 30) && (accepted < 2); i++) applyStimulus();
    check("ab_two_accepted", accepted, 2);
    check("ab_words_left_pre", words_left, 8'd4);
    m_ready = 1'b0;
    abort   = 1'b1;
    applyStimulus();
    abort   = 1'b0;
    check("ab_valid_dropped", m_valid, 1'b0);
    check("ab_done", done, 1'b1);
    check("ab_aborted", aborted, 1'b1);
    check("ab_words_left", words_left, 8'h00);
    check("ab_idle", busy, 1'b0);
    check("ab_re_en", fifo_re_en, 1'b0);
    applyStimulus();
    check("ab_done_pulse", done, 1'b0);
    check("ab_aborted_pulse", aborted, 1'b0);
    check("ab_valid_stays_low", m_valid, 1'b0);
    expQ.delete();
    abort = 1'b1;
    applyStimulus();
    abort = 1'b0;
    check("ab_idle_no_done", done, 1'b0);
    check("ab_idle_no_aborted", aborted, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
